// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the instruction ROM, buffers {pc, word} pairs
// in a small queue for decode, and handles branch redirects and end-of-program halts.
module imem_fetch_ctrl #(
  parameter int              N            = 32,
  parameter int              AW           = 6,
  parameter int              PCW          = 64,
  parameter int              DEPTH        = 4,
  parameter logic [PCW-1:0]  RESET_PC     = '0,
  parameter bit              HALT_ON_ZERO = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic [AW-1:0]              imem_addr,
  input  logic [N-1:0]               imem_q,
  input  logic                       redirect,
  input  logic [PCW-1:0]             redirect_pc,
  output logic                       inst_valid,
  output logic [N-1:0]               inst,
  output logic [PCW-1:0]             inst_pc,
  input  logic                       inst_ready,
  output logic                       halted,
  output logic                       fetch_fault,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PCW-1:0]  pc, pc_nxt;
  logic            fault_nxt;

  logic [N-1:0]    mem_inst [DEPTH];
  logic [PCW-1:0]  mem_pc   [DEPTH];
  logic [PTRW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [N-1:0]    last_inst;
  logic [PCW-1:0]  last_pc;

  logic            push, pop, flush;
  logic            pc_legal, has_space, zero_word;

  assign imem_addr  = pc[AW+1:2];
  assign pc_legal   = (pc[1:0] == 2'b00) && (pc[PCW-1:AW+2] == '0);
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign has_space  = (count < CW'(DEPTH)) || pop;
  assign zero_word  = HALT_ON_ZERO && (imem_q == '0);
  assign flush      = redirect && (state != S_IDLE);

  assign halted  = (state == S_HALT);
  assign q_count = count;

  // The head is read straight from the queue; once empty, the last shown head is held.
  assign inst    = inst_valid ? mem_inst[rd_ptr] : last_inst;
  assign inst_pc = inst_valid ? mem_pc[rd_ptr]   : last_pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_nxt = fetch_fault;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (redirect) pc_nxt = redirect_pc;
        if (start)    state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          fault_nxt = 1'b0;
        end else if (!pc_legal) begin
          state_nxt = S_HALT;
          fault_nxt = 1'b1;
        end else if (has_space) begin
          // A zero word marks end of program: stop without queuing it.
          if (zero_word) begin
            state_nxt = S_HALT;
          end else begin
            push   = 1'b1;
            pc_nxt = pc + PCW'(4);
          end
        end
      end
      S_HALT: begin
        if (redirect) begin
          state_nxt = S_FETCH;
          pc_nxt    = redirect_pc;
          fault_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_fault <= fault_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_inst <= '0;
      last_pc   <= '0;
    end else if (inst_valid) begin
      last_inst <= mem_inst[rd_ptr];
      last_pc   <= mem_pc[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= imem_q;
      mem_pc[wr_ptr]   <= pc;
    end
  end

endmodule
